// File: rtl/ccip_rd_mux_pkg.sv
// Shared widths and helpers for the CCI-P read request multiplexer.
package ccip_rd_mux_pkg;

  localparam int MDATA_W    = 16;
  localparam int RSP_DATA_W = 512;
  // Outstanding counters must hold up to 255 in-flight reads.
  localparam int CNT_W      = 8;

  function automatic int chIdWidth(input int nCh);
    return (nCh < 2) ? 1 : $clog2(nCh);
  endfunction

endpackage

// File: rtl/ccip_rr_arbiter.sv
// Round-robin selector: first eligible channel at or after ptr wins, one-hot out.
module ccip_rr_arbiter
  import ccip_rd_mux_pkg::*;
#(
  parameter int N_CHANNELS = 4,
  parameter int PTR_W      = chIdWidth(N_CHANNELS)
)(
  input  logic [N_CHANNELS-1:0] eligible,
  input  logic [PTR_W-1:0]      ptr,
  output logic [N_CHANNELS-1:0] grant
);

  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      if (int'(ptr) + k >= N_CHANNELS) idx = PTR_W'(int'(ptr) + k - N_CHANNELS);
      else                             idx = PTR_W'(int'(ptr) + k);
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccip_rd_mux.sv
// N-channel read mux onto one CCI-P c0 port with per-channel credit tracking.
// Optional per-channel grant counters: define CCIP_RD_MUX_STATS_EN.
module ccip_rd_mux
  import ccip_rd_mux_pkg::*;
#(
  parameter int  N_CHANNELS      = 4,
  parameter int  MAX_OUTSTANDING = 64,
  parameter int  ADDR_WIDTH      = 42,
  localparam int CH_ID_W         = chIdWidth(N_CHANNELS),
  localparam int TAG_W           = MDATA_W - CH_ID_W
)(
  input  logic                             pClk,
  input  logic                             pReset,
  input  logic [N_CHANNELS-1:0]            req_valid,
  input  logic [N_CHANNELS*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_CHANNELS*TAG_W-1:0]      req_mdata,
  output logic [N_CHANNELS-1:0]            req_ready,
  output logic                             c0_req_valid,
  output logic [ADDR_WIDTH-1:0]            c0_req_addr,
  output logic [MDATA_W-1:0]               c0_req_mdata,
  input  logic                             c0_almost_full,
  input  logic                             c0_rsp_valid,
  input  logic [MDATA_W-1:0]               c0_rsp_mdata,
  input  logic [RSP_DATA_W-1:0]            c0_rsp_data,
  output logic [N_CHANNELS-1:0]            rsp_valid,
  output logic [TAG_W-1:0]                 rsp_mdata,
  output logic [RSP_DATA_W-1:0]            rsp_data,
  output logic                             err_sticky
`ifdef CCIP_RD_MUX_STATS_EN
  ,
  output logic [N_CHANNELS*32-1:0]         stat_req_cnt
`endif
);

  logic [CNT_W-1:0]      outstanding [N_CHANNELS];
  logic [CH_ID_W-1:0]    rrPtr;
  logic [N_CHANNELS-1:0] eligible;
  logic [N_CHANNELS-1:0] cntNonZero;
  logic [N_CHANNELS-1:0] grant;
  logic [N_CHANNELS-1:0] rspHit;
  logic [CH_ID_W-1:0]    grantId;
  logic [CH_ID_W-1:0]    rspId;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [TAG_W-1:0]      selTag;
  logic                  rspOk;
  logic                  rspBad;

  logic                  reqVld_p1;
  logic [ADDR_WIDTH-1:0] reqAddr_p1;
  logic [MDATA_W-1:0]    reqMdata_p1;
  logic [N_CHANNELS-1:0] rspVld_p1;
  logic [TAG_W-1:0]      rspMdata_p1;
  logic [RSP_DATA_W-1:0] rspData_p1;
  logic                  errSticky;

  // Backpressure, reset and a full credit window all remove a channel from contention.
  always_comb begin
    eligible   = '0;
    cntNonZero = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      eligible[i]   = req_valid[i] && !c0_almost_full && !pReset &&
                      (outstanding[i] != CNT_W'(MAX_OUTSTANDING));
      cntNonZero[i] = (outstanding[i] != '0);
    end
  end

  ccip_rr_arbiter #(
    .N_CHANNELS (N_CHANNELS),
    .PTR_W      (CH_ID_W)
  ) uArb (
    .eligible (eligible),
    .ptr      (rrPtr),
    .grant    (grant)
  );

  assign req_ready = grant;

  always_comb begin
    grantId = '0;
    selAddr = '0;
    selTag  = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (grant[i]) begin
        grantId = CH_ID_W'(i);
        selAddr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        selTag  = req_mdata[i*TAG_W +: TAG_W];
      end
    end
  end

  // A response only routes to an existing channel that actually has a read in flight.
  assign rspId = c0_rsp_mdata[MDATA_W-1 -: CH_ID_W];

  always_comb begin
    rspHit = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      rspHit[i] = c0_rsp_valid && (rspId == CH_ID_W'(i)) && cntNonZero[i];
    end
  end

  assign rspOk  = |rspHit;
  assign rspBad = c0_rsp_valid && !rspOk;

  // ---- stage p1: registered host request and routed response ----
  always_ff @(posedge pClk) begin
    if (pReset) begin
      reqVld_p1   <= 1'b0;
      reqAddr_p1  <= '0;
      reqMdata_p1 <= '0;
      rspVld_p1   <= '0;
      rspMdata_p1 <= '0;
      rspData_p1  <= '0;
      errSticky   <= 1'b0;
    end else begin
      reqVld_p1 <= |grant;
      if (|grant) begin
        reqAddr_p1  <= selAddr;
        reqMdata_p1 <= {grantId, selTag};
      end
      rspVld_p1 <= rspHit;
      if (rspOk) begin
        rspMdata_p1 <= c0_rsp_mdata[TAG_W-1:0];
        rspData_p1  <= c0_rsp_data;
      end
      if (rspBad) errSticky <= 1'b1;
    end
  end

  always_ff @(posedge pClk) begin
    if (pReset) begin
      rrPtr <= '0;
      for (int i = 0; i < N_CHANNELS; i++) outstanding[i] <= '0;
    end else begin
      if (|grant) rrPtr <= (grantId == CH_ID_W'(N_CHANNELS - 1)) ? '0 : grantId + 1'b1;
      for (int i = 0; i < N_CHANNELS; i++) begin
        if (grant[i] && !rspHit[i])      outstanding[i] <= outstanding[i] + 1'b1;
        else if (!grant[i] && rspHit[i]) outstanding[i] <= outstanding[i] - 1'b1;
      end
    end
  end

  assign c0_req_valid = reqVld_p1;
  assign c0_req_addr  = reqAddr_p1;
  assign c0_req_mdata = reqMdata_p1;
  assign rsp_valid    = rspVld_p1;
  assign rsp_mdata    = rspMdata_p1;
  assign rsp_data     = rspData_p1;
  assign err_sticky   = errSticky;

`ifdef CCIP_RD_MUX_STATS_EN
  logic [31:0] statCnt [N_CHANNELS];

  function automatic logic [31:0] satInc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge pClk) begin
    if (pReset) begin
      for (int i = 0; i < N_CHANNELS; i++) statCnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CHANNELS; i++) begin
        if (grant[i]) statCnt[i] <= satInc32(statCnt[i]);
      end
    end
  end

  always_comb begin
    stat_req_cnt = '0;
    for (int i = 0; i < N_CHANNELS; i++) stat_req_cnt[i*32 +: 32] = statCnt[i];
  end
`endif

endmodule

// File: tb/tb_ccip_rd_mux.sv
// Directed bench: a 4-channel mux with a credit window of 2, plus a 3-channel mux for bad ids.
module tb_ccip_rd_mux;
  import ccip_rd_mux_pkg::*;

  localparam int NCH  = 4;
  localparam int NCH3 = 3;
  localparam int AW   = 42;
  localparam int TW   = 14;

  logic pClk = 1'b0;
  logic pReset;
  always #5 pClk = ~pClk;

  logic [NCH-1:0]        reqValid;
  logic [NCH*AW-1:0]     reqAddr;
  logic [NCH*TW-1:0]     reqMdata;
  logic [NCH-1:0]        reqReady;
  logic                  c0ReqValid;
  logic [AW-1:0]         c0ReqAddr;
  logic [15:0]           c0ReqMdata;
  logic                  almostFull;
  logic                  rspValidIn;
  logic [15:0]           rspMdataIn;
  logic [511:0]          rspDataIn;
  logic [NCH-1:0]        rspValid;
  logic [TW-1:0]         rspMdata;
  logic [511:0]          rspData;
  logic                  errSticky;

  logic [NCH3-1:0]       reqValid3;
  logic [NCH3*AW-1:0]    reqAddr3;
  logic [NCH3*TW-1:0]    reqMdata3;
  logic [NCH3-1:0]       reqReady3;
  logic                  c0ReqValid3;
  logic [AW-1:0]         c0ReqAddr3;
  logic [15:0]           c0ReqMdata3;
  logic                  rspValidIn3;
  logic [15:0]           rspMdataIn3;
  logic [NCH3-1:0]       rspValid3;
  logic [TW-1:0]         rspMdata3;
  logic [511:0]          rspData3;
  logic                  errSticky3;
`ifdef CCIP_RD_MUX_STATS_EN
  logic [NCH*32-1:0]     statReqCnt;
  logic [NCH3*32-1:0]    statReqCnt3;
`endif

  ccip_rd_mux #(.N_CHANNELS(NCH), .MAX_OUTSTANDING(2), .ADDR_WIDTH(AW)) u0 (
    .pClk(pClk), .pReset(pReset),
    .req_valid(reqValid), .req_addr(reqAddr), .req_mdata(reqMdata), .req_ready(reqReady),
    .c0_req_valid(c0ReqValid), .c0_req_addr(c0ReqAddr), .c0_req_mdata(c0ReqMdata),
    .c0_almost_full(almostFull),
    .c0_rsp_valid(rspValidIn), .c0_rsp_mdata(rspMdataIn), .c0_rsp_data(rspDataIn),
    .rsp_valid(rspValid), .rsp_mdata(rspMdata), .rsp_data(rspData),
    .err_sticky(errSticky)
`ifdef CCIP_RD_MUX_STATS_EN
    , .stat_req_cnt(statReqCnt)
`endif
  );

  ccip_rd_mux #(.N_CHANNELS(NCH3), .MAX_OUTSTANDING(2), .ADDR_WIDTH(AW)) u3 (
    .pClk(pClk), .pReset(pReset),
    .req_valid(reqValid3), .req_addr(reqAddr3), .req_mdata(reqMdata3), .req_ready(reqReady3),
    .c0_req_valid(c0ReqValid3), .c0_req_addr(c0ReqAddr3), .c0_req_mdata(c0ReqMdata3),
    .c0_almost_full(almostFull),
    .c0_rsp_valid(rspValidIn3), .c0_rsp_mdata(rspMdataIn3), .c0_rsp_data(rspDataIn),
    .rsp_valid(rspValid3), .rsp_mdata(rspMdata3), .rsp_data(rspData3),
    .err_sticky(errSticky3)
`ifdef CCIP_RD_MUX_STATS_EN
    , .stat_req_cnt(statReqCnt3)
`endif
  );

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Channel ch was granted last cycle: address 0x100+ch, tag 0x10+ch, id in [15:14].
  task automatic expectReq(input string tag, input int ch);
    checkVal({tag, "_vld"},   64'(c0ReqValid), 64'd1);
    checkVal({tag, "_mdata"}, 64'(c0ReqMdata), 64'((ch << 14) | (16 + ch)));
    checkVal({tag, "_addr"},  64'(c0ReqAddr),  64'(32'h100 + ch));
  endtask

  task automatic step();
    @(posedge pClk);
    #1;
  endtask

  initial begin
    pReset      = 1'b1;
    reqValid    = '0;
    almostFull  = 1'b0;
    rspValidIn  = 1'b0;
    rspMdataIn  = '0;
    rspDataIn   = '0;
    reqValid3   = '0;
    reqAddr3    = '0;
    reqMdata3   = '0;
    rspValidIn3 = 1'b0;
    rspMdataIn3 = '0;
    for (int i = 0; i < NCH; i++) begin
      reqAddr[i*AW +: AW]  = AW'(32'h100 + i);
      reqMdata[i*TW +: TW] = TW'(16 + i);
    end

    repeat (2) step();
    @(negedge pClk);
    checkVal("rst_c0_vld",   64'(c0ReqValid), 64'd0);
    checkVal("rst_c0_addr",  64'(c0ReqAddr),  64'd0);
    checkVal("rst_c0_mdata", 64'(c0ReqMdata), 64'd0);
    checkVal("rst_rsp_vld",  64'(rspValid),   64'd0);
    checkVal("rst_rsp_data", rspData[63:0],   64'd0);
    checkVal("rst_err",      64'(errSticky),  64'd0);

    // Round robin with every channel requesting
    step();
    pReset   = 1'b0;
    reqValid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge pClk);
      checkVal($sformatf("rr_grant%0d", k), 64'(reqReady), 64'(1 << (k % 4)));
      if (k > 0) expectReq($sformatf("rr_req%0d", k - 1), (k - 1) % 4);
      step();
    end

    // Every channel now holds 2 credits; free one on ch3 while ch1 stays full
    reqValid   = 4'b1010;
    rspValidIn = 1'b1;
    rspMdataIn = 16'hC007;
    rspDataIn  = {8{64'hDEAD_BEEF_0000_0007}};
    @(negedge pClk);
    expectReq("rr_req7", 3);
    checkVal("full_block", 64'(reqReady), 64'd0);
    step();
    rspValidIn = 1'b0;
    @(negedge pClk);
    checkVal("rsp3_vld",   64'(rspValid),     64'b1000);
    checkVal("rsp3_mdata", 64'(rspMdata),     64'h7);
    checkVal("rsp3_lo",    rspData[63:0],     64'hDEAD_BEEF_0000_0007);
    checkVal("rsp3_hi",    rspData[511:448],  64'hDEAD_BEEF_0000_0007);
    checkVal("skip_ch1",   64'(reqReady),     64'b1000);
    checkVal("idle_c0",    64'(c0ReqValid),   64'd0);
    step();
    rspValidIn = 1'b1;
    rspMdataIn = 16'h4003;
    @(negedge pClk);
    checkVal("ch1_still_full", 64'(reqReady), 64'd0);
    expectReq("skip_req", 3);
    step();
    rspValidIn = 1'b0;
    @(negedge pClk);
    checkVal("rsp1_vld",   64'(rspValid), 64'b0010);
    checkVal("rsp1_mdata", 64'(rspMdata), 64'h3);
    checkVal("ch1_eligible", 64'(reqReady), 64'b0010);
    step();
    reqValid = '0;
    @(negedge pClk);
    expectReq("ch1_req", 1);

    // Response routing with id 2
    step();
    rspValidIn = 1'b1;
    rspMdataIn = 16'h8005;
    rspDataIn  = {8{64'h0123_4567_89AB_CDEF}};
    @(negedge pClk);
    checkVal("rsp_lat", 64'(rspValid), 64'd0);
    step();
    rspValidIn = 1'b0;
    @(negedge pClk);
    checkVal("rsp2_vld",   64'(rspValid),    64'b0100);
    checkVal("rsp2_mdata", 64'(rspMdata),    64'h0005);
    checkVal("rsp2_lo",    rspData[63:0],    64'h0123_4567_89AB_CDEF);

    // Host backpressure holds ch2 off
    step();
    almostFull = 1'b1;
    reqValid   = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      @(negedge pClk);
      checkVal($sformatf("af_ready%0d", k), 64'(reqReady),   64'd0);
      checkVal($sformatf("af_c0vld%0d", k), 64'(c0ReqValid), 64'd0);
      step();
    end
    almostFull = 1'b0;
    @(negedge pClk);
    checkVal("af_drop_grant", 64'(reqReady),   64'b0100);
    checkVal("af_drop_c0vld", 64'(c0ReqValid), 64'd0);
    step();
    reqValid = '0;
    @(negedge pClk);
    expectReq("af_req", 2);

    // Same-cycle grant and response on ch0 keeps its count at 1
    step();
    rspValidIn = 1'b1;
    rspMdataIn = 16'h0001;
    step();
    rspMdataIn = 16'h0002;
    reqValid   = 4'b0001;
    @(negedge pClk);
    checkVal("same_cyc_grant", 64'(reqReady), 64'b0001);
    step();
    rspValidIn = 1'b0;
    @(negedge pClk);
    checkVal("cnt_kept",      64'(reqReady), 64'b0001);
    checkVal("rsp0_vld",      64'(rspValid), 64'b0001);
    checkVal("rsp0_mdata",    64'(rspMdata), 64'h0002);
    step();
    @(negedge pClk);
    checkVal("cnt_full",      64'(reqReady), 64'd0);
    checkVal("no_err_yet",    64'(errSticky), 64'd0);
`ifdef CCIP_RD_MUX_STATS_EN
    checkVal("stat_ch0", 64'(statReqCnt[31:0]),   64'd4);
    checkVal("stat_ch1", 64'(statReqCnt[63:32]),  64'd3);
    checkVal("stat_ch2", 64'(statReqCnt[95:64]),  64'd3);
    checkVal("stat_ch3", 64'(statReqCnt[127:96]), 64'd3);
`endif
    step();
    reqValid = '0;

    // Id 3 does not exist on the 3-channel mux
    rspValidIn3 = 1'b1;
    rspMdataIn3 = 16'hC001;
    step();
    rspValidIn3 = 1'b0;
    @(negedge pClk);
    checkVal("bad_id_vld", 64'(rspValid3),  64'd0);
    checkVal("bad_id_err", 64'(errSticky3), 64'd1);
    repeat (3) step();
    @(negedge pClk);
    checkVal("err_hold",   64'(errSticky3), 64'd1);

    // Reset mid-flight; a response arriving afterwards has no credit to return
    step();
    pReset     = 1'b1;
    rspValidIn = 1'b1;
    rspMdataIn = 16'h4009;
    reqValid   = 4'b0010;
    @(negedge pClk);
    checkVal("rst_no_grant", 64'(reqReady), 64'd0);
    step();
    pReset = 1'b0;
    @(negedge pClk);
    checkVal("rst_rsp_drop",  64'(rspValid),   64'd0);
    checkVal("rst_c0_clear",  64'(c0ReqValid), 64'd0);
    checkVal("err_cleared",   64'(errSticky3), 64'd0);
    checkVal("cnt_cleared",   64'(reqReady),   64'b0010);
    step();
    rspValidIn = 1'b0;
    reqValid   = '0;
    @(negedge pClk);
    checkVal("late_rsp_drop", 64'(rspValid),  64'd0);
    checkVal("late_rsp_err",  64'(errSticky), 64'd1);
    expectReq("post_rst_req", 1);
`ifdef CCIP_RD_MUX_STATS_EN
    checkVal("stat_rst_ch0", 64'(statReqCnt[31:0]),  64'd0);
    checkVal("stat_rst_ch1", 64'(statReqCnt[63:32]), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
